segre_mm_ctrl: RTL and testbench

Main-memory controller sitting directly downstream of the core's MMU main-memory port. It consumes lane-wide read/write requests and models a fixed-latency backing store holding whole cache lanes. It returns read data with a one-cycle ready pulse. It serialises simultaneous writeback+fill requests so the MMU never sees lost requests.

---
 rtl/segre_pkg.sv | 21 ++
 rtl/segre_mm_array.sv | 30 +++
 rtl/segre_mm_ctrl.sv | 175 +++++++++++++++++
 tb/tb_segre_mm_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/segre_pkg.sv
// Shared types and constants for the segre main-memory path.
package segre_pkg;

   localparam int DC_LANE_W = 128;
   localparam int MM_LANE_W = DC_LANE_W;
   localparam int MM_ADDR_W = 32;

   typedef enum logic [1:0] {
      MM_IDLE,
      MM_WR_WAIT,
      MM_RD_WAIT,
      MM_RESP
   } mm_state_e;

   typedef struct packed {
      logic [MM_ADDR_W-1:0] addr;
      logic [MM_LANE_W-1:0] data;
      logic                 is_wr;
   } mm_req_t;

endpackage

// File: rtl/segre_mm_array.sv
// Single-port lane RAM for the main-memory model; read data is registered
// and only updates on a read strobe. Contents are never reset.
module segre_mm_array #(
   parameter int LANE_W    = 128,
   parameter int MEM_LANES = 1024,
   parameter int IDX_W     = $clog2(MEM_LANES)
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic              re_i,
   input  logic [IDX_W-1:0]  idx_i,
   input  logic [LANE_W-1:0] wdata_i,
   output logic [LANE_W-1:0] rdata_o
);

   logic [LANE_W-1:0] mem_q [MEM_LANES];
   logic [LANE_W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[idx_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[idx_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/segre_mm_ctrl.sv
// Fixed-latency main-memory controller behind the MMU; serialises write+read.
// Optional macro SEGRE_MM_PERF_CNT_EN adds saturating rd/wr completion counters.
//
// state      | meaning
// MM_IDLE    | waiting for a request; write wins over a simultaneous read
// MM_WR_WAIT | write latency countdown, commits to the array on terminal count
// MM_RD_WAIT | read latency countdown, registers the lane on terminal count
// MM_RESP    | one-cycle completion pulse; replays a pending read if any
module segre_mm_ctrl
   import segre_pkg::*;
#(
   parameter int LANE_W    = MM_LANE_W,
   parameter int ADDR_W    = MM_ADDR_W,
   parameter int MEM_LANES = 1024,
   parameter int LATENCY   = 4
) (
   input  logic              clk_i,
   input  logic              rsn_i,
   input  logic              mm_rd_i,
   input  logic              mm_wr_i,
   input  logic [ADDR_W-1:0] mm_addr_i,
   input  logic [ADDR_W-1:0] mm_wr_addr_i,
   input  logic [LANE_W-1:0] mm_wr_data_i,
   output logic              mm_data_rdy_o,
   output logic [LANE_W-1:0] mm_rd_data_o,
   output logic              mm_busy_o
`ifdef SEGRE_MM_PERF_CNT_EN
   ,
   output logic [31:0]       rd_count_o,
   output logic [31:0]       wr_count_o
`endif
);

   localparam int OFF_W = $clog2(LANE_W/8);
   localparam int IDX_W = $clog2(MEM_LANES);
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY-1);

   mm_state_e         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              pend_rd_q, pend_rd_d;
   logic              rd_vld_q, rd_vld_d;
   logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
   logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
   logic [LANE_W-1:0] wr_data_q, wr_data_d;

   logic              arr_we, arr_re;
   logic [IDX_W-1:0]  arr_idx;
   logic [LANE_W-1:0] arr_rdata;

   logic [IDX_W-1:0]  rd_idx_in, wr_idx_in;
   logic              unused_addr_bits;

   // Offset bits and bits above the lane index are dropped, so addresses wrap.
   assign rd_idx_in = mm_addr_i[OFF_W+IDX_W-1:OFF_W];
   assign wr_idx_in = mm_wr_addr_i[OFF_W+IDX_W-1:OFF_W];
   assign unused_addr_bits = ^{mm_addr_i[ADDR_W-1:OFF_W+IDX_W], mm_addr_i[OFF_W-1:0],
                               mm_wr_addr_i[ADDR_W-1:OFF_W+IDX_W], mm_wr_addr_i[OFF_W-1:0]};

   always_ff @(posedge clk_i) begin
      if (rsn_i) begin
         state_q   <= MM_IDLE;
         cnt_q     <= '0;
         pend_rd_q <= 1'b0;
         rd_vld_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pend_rd_q <= pend_rd_d;
         rd_vld_q  <= rd_vld_d;
      end
   end

   always_ff @(posedge clk_i) begin
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      wr_data_q <= wr_data_d;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pend_rd_d = pend_rd_q;
      rd_vld_d  = rd_vld_q;
      wr_idx_d  = wr_idx_q;
      rd_idx_d  = rd_idx_q;
      wr_data_d = wr_data_q;
      case (state_q)
         MM_IDLE: begin
            if (mm_wr_i) begin
               wr_idx_d  = wr_idx_in;
               wr_data_d = mm_wr_data_i;
               state_d   = MM_WR_WAIT;
               cnt_d     = CNT_LOAD;
               if (mm_rd_i) begin
                  rd_idx_d  = rd_idx_in;
                  pend_rd_d = 1'b1;
               end
            end else if (mm_rd_i) begin
               rd_idx_d = rd_idx_in;
               state_d  = MM_RD_WAIT;
               cnt_d    = CNT_LOAD;
            end
         end
         MM_WR_WAIT, MM_RD_WAIT: begin
            if (cnt_q == '0) begin
               state_d = MM_RESP;
               if (state_q == MM_RD_WAIT) begin
                  rd_vld_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         MM_RESP: begin
            // A pending read was captured with the write; no re-sampling here.
            if (pend_rd_q) begin
               pend_rd_d = 1'b0;
               state_d   = MM_RD_WAIT;
               cnt_d     = CNT_LOAD;
            end else begin
               state_d = MM_IDLE;
            end
         end
         default: state_d = MM_IDLE;
      endcase
   end

   always_comb begin
      mm_data_rdy_o = (state_q == MM_RESP);
      mm_busy_o     = (state_q != MM_IDLE);
      // Gated by reset so an aborted operation never touches the array.
      arr_we  = (state_q == MM_WR_WAIT) && (cnt_q == '0) && !rsn_i;
      arr_re  = (state_q == MM_RD_WAIT) && (cnt_q == '0) && !rsn_i;
      arr_idx = (state_q == MM_WR_WAIT) ? wr_idx_q : rd_idx_q;
   end

   assign mm_rd_data_o = rd_vld_q ? arr_rdata : '0;

   segre_mm_array #(
      .LANE_W    (LANE_W),
      .MEM_LANES (MEM_LANES),
      .IDX_W     (IDX_W)
   ) u_array (
      .clk_i   (clk_i),
      .we_i    (arr_we),
      .re_i    (arr_re),
      .idx_i   (arr_idx),
      .wdata_i (wr_data_q),
      .rdata_o (arr_rdata)
   );

`ifdef SEGRE_MM_PERF_CNT_EN
   logic        resp_wr_q;
   logic [31:0] rd_cnt_q, wr_cnt_q;

   always_ff @(posedge clk_i) begin
      resp_wr_q <= (state_q == MM_WR_WAIT);
      if (rsn_i) begin
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else if (state_q == MM_RESP) begin
         if (resp_wr_q) begin
            if (wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + 32'd1;
         end else begin
            if (rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + 32'd1;
         end
      end
   end

   assign rd_count_o = rd_cnt_q;
   assign wr_count_o = wr_cnt_q;
`endif

endmodule

// File: tb/tb_segre_mm_ctrl.sv
// Bench for segre_mm_ctrl: event-queue memory model plus directed requests.
// Counter checks are compiled in when SEGRE_MM_PERF_CNT_EN is defined.
module tb_segre_mm_ctrl;
   localparam int L = 4;

   logic         clk = 1'b0;
   logic         rsn = 1'b1;
   logic         rd = 1'b0, wr = 1'b0;
   logic [31:0]  addr = '0, wr_addr = '0;
   logic [127:0] wr_data = '0;
   logic         rdy, busy;
   logic [127:0] rd_data;
`ifdef SEGRE_MM_PERF_CNT_EN
   logic [31:0]  rd_count, wr_count;
`endif

   always #5 clk = ~clk;

   segre_mm_ctrl #(.LANE_W(128), .ADDR_W(32), .MEM_LANES(1024), .LATENCY(L)) dut (
      .clk_i         (clk),
      .rsn_i         (rsn),
      .mm_rd_i       (rd),
      .mm_wr_i       (wr),
      .mm_addr_i     (addr),
      .mm_wr_addr_i  (wr_addr),
      .mm_wr_data_i  (wr_data),
      .mm_data_rdy_o (rdy),
      .mm_rd_data_o  (rd_data),
      .mm_busy_o     (busy)
`ifdef SEGRE_MM_PERF_CNT_EN
      ,
      .rd_count_o    (rd_count),
      .wr_count_o    (wr_count)
`endif
   );

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   bit chk_en = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: each accepted request becomes a completion event at a due cycle.
   typedef struct {
      int           due;
      bit           is_rd;
      int           idx;
      logic [127:0] wdata;
   } ev_t;

   ev_t          evq[$];
   ev_t          ev;
   logic [127:0] mmem [1024];
   bit           m_rdy = 0, m_busy = 0, m_isrd = 0, was_busy;
   logic [127:0] m_rdata = '0;
   int           m_rd_cnt = 0, m_wr_cnt = 0;

   function automatic int lane(input logic [31:0] a);
      return (int'(a) / 16) % 1024;
   endfunction

   always @(posedge clk) begin
      cyc++;
      if (rsn) begin
         evq.delete();
         m_rdy = 0; m_busy = 0; m_isrd = 0; m_rdata = '0;
         m_rd_cnt = 0; m_wr_cnt = 0;
      end else begin
         if (m_rdy) begin
            if (m_isrd) m_rd_cnt++; else m_wr_cnt++;
         end
         was_busy = m_busy;
         m_rdy = 0; m_isrd = 0;
         if (evq.size() > 0 && evq[0].due == cyc) begin
            ev = evq.pop_front();
            m_rdy = 1;
            m_isrd = ev.is_rd;
            if (ev.is_rd) m_rdata = mmem[ev.idx];
            else mmem[ev.idx] = ev.wdata;
         end
         if (!was_busy && (rd || wr)) begin
            if (wr) evq.push_back('{cyc + L, 1'b0, lane(wr_addr), wr_data});
            if (rd) evq.push_back('{(wr ? cyc + 2*L + 1 : cyc + L), 1'b1, lane(addr), 128'h0});
         end
         m_busy = (evq.size() > 0) || m_rdy;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("rdy", rdy, m_rdy);
         chk("busy", busy, m_busy);
         if (m_rdy && m_isrd) chk("rd_data", rd_data, m_rdata);
`ifdef SEGRE_MM_PERF_CNT_EN
         chk("rd_count", rd_count, m_rd_cnt);
         chk("wr_count", wr_count, m_wr_cnt);
`endif
      end
   end

   task automatic req(input bit r, input bit w, input logic [31:0] ra, input logic [31:0] wa,
                      input logic [127:0] wd, output int lat1, output int lat2,
                      output logic [127:0] d);
      int acc, n, need;
      @(negedge clk);
      rd = r; wr = w; addr = ra; wr_addr = wa; wr_data = wd;
      acc = cyc + 1;
      need = (r && w) ? 2 : 1;
      n = 0; lat1 = -1; lat2 = -1; d = '0;
      for (int i = 0; i < 40 && n < need; i++) begin
         @(negedge clk);
         if (rdy) begin
            n++;
            if (n == 1) begin lat1 = cyc - acc; wr = 0; end
            else lat2 = cyc - acc;
            d = rd_data;
         end
      end
      rd = 0; wr = 0;
      if (n < need) begin
         vectors++;
         miscompares++;
         $display("FAIL req_timeout: got %0d pulses expected %0d", n, need);
      end
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rsn = 1; rd = 0; wr = 0;
      repeat (n) @(negedge clk);
      rsn = 0;
   endtask

   localparam logic [127:0] D_BEEF = 128'h0123_4567_89ab_cdef_0000_0000_dead_beef;
   localparam logic [127:0] D_A5   = {4{32'ha5a5_a5a5}};
   localparam logic [127:0] D_WRAP = 128'hfeed_0001_0002_0003_0004_0005_0006_0007;
   localparam logic [127:0] D_OLD  = 128'h1111_1111_1111_1111_1111_1111_1111_1111;
   localparam logic [127:0] D_NEW  = 128'h2222_2222_2222_2222_2222_2222_2222_2222;

   initial begin
      int l1, l2, pulses;
      logic [127:0] d;

      repeat (3) @(negedge clk);
      rsn = 0;
      chk_en = 1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_rdy", rdy, 0);
         chk("idle_busy", busy, 0);
         chk("idle_rd_data", rd_data, 0);
      end

      req(0, 1, 32'h0, 32'h40, D_BEEF, l1, l2, d);
      chk("wr_latency", l1, 4);
      @(negedge clk);
      req(1, 0, 32'h40, 32'h0, '0, l1, l2, d);
      chk("rd_latency", l1, 4);
      chk("rd_beef", d, D_BEEF);

      req(1, 1, 32'h40, 32'h40, D_A5, l1, l2, d);
      chk("dual_wr_latency", l1, 4);
      chk("dual_rd_latency", l2, 9);
      chk("dual_rd_data", d, D_A5);

      req(0, 1, 32'h0, 32'h4040, D_WRAP, l1, l2, d);
      req(1, 0, 32'h0040, 32'h0, '0, l1, l2, d);
      chk("wrap_rd", d, D_WRAP);
      req(1, 0, 32'h004c, 32'h0, '0, l1, l2, d);
      chk("offset_rd", d, D_WRAP);

      // Read aborted by reset two cycles after acceptance.
      pulses = 0;
      @(negedge clk);
      rd = 1; addr = 32'h80;
      @(negedge clk);
      if (rdy) pulses++;
      @(negedge clk);
      if (rdy) pulses++;
      rsn = 1; rd = 0;
      @(negedge clk);
      rsn = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rdy) pulses++;
      end
      chk("rd_abort_pulses", pulses, 0);
      req(1, 0, 32'h40, 32'h0, '0, l1, l2, d);
      chk("post_abort_rd", d, D_WRAP);
      chk("post_abort_lat", l1, 4);

      // Write aborted on the very edge it would commit.
      req(0, 1, 32'h0, 32'h80, D_OLD, l1, l2, d);
      pulses = 0;
      @(negedge clk);
      wr = 1; wr_addr = 32'h80; wr_data = D_NEW;
      repeat (4) begin
         @(negedge clk);
         if (rdy) pulses++;
      end
      rsn = 1; wr = 0;
      @(negedge clk);
      rsn = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (rdy) pulses++;
      end
      chk("wr_abort_pulses", pulses, 0);
      req(1, 0, 32'h80, 32'h0, '0, l1, l2, d);
      chk("wr_abort_array", d, D_OLD);

`ifdef SEGRE_MM_PERF_CNT_EN
      do_reset(1);
      req(1, 0, 32'h40, 32'h0, '0, l1, l2, d);
      req(0, 1, 32'h0, 32'hc0, D_NEW, l1, l2, d);
      req(1, 0, 32'h80, 32'h0, '0, l1, l2, d);
      req(0, 1, 32'h0, 32'hc0, D_OLD, l1, l2, d);
      req(1, 0, 32'hc0, 32'h0, '0, l1, l2, d);
      @(negedge clk);
      chk("perf_rd", rd_count, 3);
      chk("perf_wr", wr_count, 2);
      do_reset(1);
      @(negedge clk);
      chk("perf_rd_rst", rd_count, 0);
      chk("perf_wr_rst", wr_count, 0);
`endif

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench timeout");
   end

endmodule
